// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings and PWM counter width.
// The optional PWM brightness stage is enabled by defining LED_PWM_EN.
package led_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    localparam int PWM_W = 4;

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// Base-tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the last count.
// A clear request overrides counting so a mode reload restarts the tick phase.
module tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: blink, chase, bounce and binary count patterns stepped every 2^speed ticks.
// Defining LED_PWM_EN adds a duty input and a 16-level PWM brightness mask on every LED.
module led_pattern_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int CH       = 18,
    parameter int TICK_DIV = 50000,
    parameter int SPD_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [SPD_W-1:0] speed,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0] duty,
`endif
    output logic [CH-1:0]    led,
    output logic             step
);

    // Wide enough to hold 2^speed-1 for the largest speed value.
    localparam int SC_W = (1 << SPD_W) - 1;

    mode_e            mode_in;
    mode_e            mode_q,     mode_d;
    logic [CH-1:0]    pat_q,      pat_d;
    logic             dir_up_q,   dir_up_d;
    logic [SC_W-1:0]  step_cnt_q, step_cnt_d;
    logic             step_q,     step_d;
    logic [SC_W-1:0]  step_lim;
    logic             tick;
    logic             reload;

    assign mode_in  = mode_e'(mode);
    assign reload   = (mode_in != mode_q);
    // Wraps to all-ones at the top speed, which is exactly 2^speed-1 in SC_W bits.
    assign step_lim = (SC_W'(1) << speed) - SC_W'(1);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (reload),
        .tick  (tick)
    );

    always_comb begin
        mode_d     = mode_q;
        pat_d      = pat_q;
        dir_up_d   = dir_up_q;
        step_cnt_d = step_cnt_q;
        step_d     = 1'b0;
        if (reload) begin
            mode_d     = mode_in;
            step_cnt_d = '0;
            dir_up_d   = 1'b1;
            pat_d      = (mode_in == MODE_CHASE || mode_in == MODE_BOUNCE) ? CH'(1) : '0;
        end else if (tick) begin
            if (step_cnt_q >= step_lim) begin
                step_cnt_d = '0;
                step_d     = 1'b1;
                case (mode_q)
                    MODE_BLINK: pat_d = ~pat_q;
                    MODE_CHASE: pat_d = {pat_q[CH-2:0], pat_q[CH-1]};
                    MODE_BOUNCE: begin
                        // Direction flips on the step that lands on an end bit.
                        if (dir_up_q) begin
                            pat_d = pat_q << 1;
                            if (pat_d[CH-1]) dir_up_d = 1'b0;
                        end else begin
                            pat_d = pat_q >> 1;
                            if (pat_d[0]) dir_up_d = 1'b1;
                        end
                    end
                    MODE_COUNT: pat_d = pat_q + CH'(1);
                    default:    pat_d = pat_q;
                endcase
            end else begin
                step_cnt_d = step_cnt_q + SC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_BLINK;
            pat_q      <= '0;
            dir_up_q   <= 1'b1;
            step_cnt_q <= '0;
            step_q     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            pat_q      <= pat_d;
            dir_up_q   <= dir_up_d;
            step_cnt_q <= step_cnt_d;
            step_q     <= step_d;
        end
    end

    assign step = step_q;

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q;
    logic             pwm_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
        end else if (en) begin
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
        end
    end

    assign pwm_on = (pwm_cnt_q < duty);

    for (genvar gi = 0; gi < CH; gi++) begin : g_pwm_mask
        assign led[gi] = pat_q[gi] & pwm_on;
    end
`else
    assign led = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (CH=8, TICK_DIV=4): a step-index reference model
// pushes the expected led/step for every clock edge and a monitor pops and compares them.
module tb_led_pattern_gen;

    localparam int CH = 8;
    localparam int TD = 4;
    localparam int SW = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic [1:0]    mode  = 2'd0;
    logic [SW-1:0] speed = '0;
    logic [CH-1:0] led;
    logic          step;
`ifdef LED_PWM_EN
    logic [3:0]    duty  = 4'd15;
`endif

    always #5 clk = ~clk;

    led_pattern_gen #(
        .CH       (CH),
        .TICK_DIV (TD),
        .SPD_W    (SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .speed (speed),
`ifdef LED_PWM_EN
        .duty  (duty),
`endif
        .led   (led),
        .step  (step)
    );

    typedef struct packed {
        logic [CH-1:0] led;
        logic          step;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;

    // Reference model state: current mode, enabled cycles since reload,
    // ticks since last step, steps since reload, enabled cycles since reset.
    int m_mode = 0;
    int m_ecyc = 0;
    int m_tss  = 0;
    int m_k    = 0;
    int m_pwm  = 0;

    function automatic logic [CH-1:0] pat_of(input int md, input int kk);
        int p;
        int pos;
        case (md)
            0: return (kk % 2 != 0) ? {CH{1'b1}} : {CH{1'b0}};
            1: return CH'(1) << (kk % CH);
            2: begin
                p   = kk % (2 * CH - 2);
                pos = (p < CH) ? p : (2 * CH - 2 - p);
                return CH'(1) << pos;
            end
            default: return CH'(kk % (1 << CH));
        endcase
    endfunction

    task automatic check(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s at t=%0t: got %h, required %h", nm, $time, act, req);
        end
    endtask

    // Called at a falling edge: drive inputs, predict the next rising edge, wait one cycle.
    task automatic cyc(input logic e, input logic [1:0] md, input logic [SW-1:0] sp);
        logic          st;
        logic [CH-1:0] l;
        en    = e;
        mode  = md;
        speed = sp;
        st    = 1'b0;
        if (int'(md) != m_mode) begin
            m_mode = int'(md);
            m_ecyc = 0;
            m_tss  = 0;
            m_k    = 0;
        end else if (e) begin
            if (m_ecyc % TD == TD - 1) begin
                m_tss++;
                if (m_tss >= (1 << sp)) begin
                    m_tss = 0;
                    m_k++;
                    st = 1'b1;
                end
            end
            m_ecyc++;
        end
        if (e) m_pwm++;
        l = pat_of(m_mode, m_k);
`ifdef LED_PWM_EN
        if (!((m_pwm % 16) < int'(duty))) l = '0;
`endif
        exp_q.push_back({l, st});
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic e, input logic [1:0] md, input logic [SW-1:0] sp);
        for (int i = 0; i < n; i++) cyc(e, md, sp);
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_ecyc = 0;
        m_tss  = 0;
        m_k    = 0;
        m_pwm  = 0;
    endtask

    // Entered at a falling edge with the scoreboard drained.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", led, '0);
        check("async_rst_step", CH'(step), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("led", led, mon_e.led);
            check("step", CH'(step), CH'(mon_e.step));
            if (step) $display("step t=%0t mode=%0d speed=%0d led=%h", $time, mode, speed, led);
        end
    end

    initial begin
        #1;
        check("reset_led", led, '0);
        check("reset_step", CH'(step), '0);
        mode = 2'd1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        run(40, 1'b1, 2'd1, 4'd0);      // chase from reset, reload on first edge
        run(60, 1'b1, 2'd2, 4'd0);      // bounce over a full period
        run(22, 1'b1, 2'd0, 4'd2);      // blink, pause mid-period, resume
        run(10, 1'b0, 2'd0, 4'd2);
        run(30, 1'b1, 2'd0, 4'd2);
        run(1030, 1'b1, 2'd3, 4'd0);    // count through the all-ones wrap
        run(12, 1'b1, 2'd1, 4'd0);      // switch to chase mid-count
        run(40, 1'b1, 2'd0, 4'd3);      // speed reduction mid-run
        run(10, 1'b1, 2'd0, 4'd0);
        run(6, 1'b1, 2'd1, 4'd0);
        async_reset();
        run(10, 1'b1, 2'd1, 4'd0);

        begin
            logic [1:0]    md;
            logic [SW-1:0] sp;
            logic          e;
            md = 2'd1;
            for (int s = 0; s < 60; s++) begin
                if ($urandom_range(0, 3) == 0) md = 2'($urandom_range(0, 3));
                sp = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
                e  = ($urandom_range(0, 9) < 8);
`ifdef LED_PWM_EN
                duty = 4'($urandom_range(0, 15));
`endif
                run($urandom_range(1, 40), e, md, sp);
                if ($urandom_range(0, 14) == 0) async_reset();
            end
        end

        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached, required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter CH, default 18: number of LED outputs (CH >= 2).
REQ-002 SHALL have parameter TICK_DIV, default 50000: clk cycles per base tick (1 ms at 50 MHz).
REQ-003 SHALL have parameter SPD_W, default 4: width of speed input.
REQ-004 SHALL have port clk  input  1  single clock for all state.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  run enable; 0 freezes all counters and the pattern.
REQ-007 SHALL have port mode  input  2  0=BLINK, 1=CHASE, 2=BOUNCE, 3=COUNT.
REQ-008 SHALL have port speed  input  SPD_W  step period = 2^speed ticks.
REQ-009 SHALL have port duty  input  4  brightness; present only with LED_PWM_EN.
REQ-010 SHALL have port led  output  CH  registered pattern output.
REQ-011 SHALL have port step  output  1  one-cycle pulse on each pattern update.

Function
REQ-012 Prescaler SHALL count 0..TICK_DIV-1 while en=1 and emit a one-cycle tick when at TICK_DIV-1, then wrap to 0.
REQ-013 Step counter SHALL count ticks; on a tick with step_cnt >= 2^speed-1, it SHALL clear and a step SHALL occur; >= (not ==) so a mid-run speed reduction steps on the next tick.
REQ-014 On a step, pattern and step pulse SHALL update on the same clk edge; step SHALL be 1 for exactly that cycle.
REQ-015 BLINK: on each step all CH bits SHALL toggle together (all-0 <-> all-1).
REQ-016 CHASE: one-hot SHALL shift left one bit per step; bit CH-1 SHALL wrap to bit 0.
REQ-017 BOUNCE: one-hot SHALL move left while dir=up; on reaching bit CH-1, dir SHALL flip to down and next step move right; on reaching bit 0, dir flips up; no repeated end position (period 2*CH-2 steps).
REQ-018 COUNT: led SHALL increment as CH-bit binary per step, wrapping all-1 -> 0.
REQ-019 SHALL register mode as mode_q; when mode != mode_q, next edge SHALL load mode_q, reload the initial pattern (BLINK all-0, CHASE/BOUNCE bit 0 with dir=up, COUNT 0), clear prescaler and step counter, and emit no step; mode change takes priority over a coincident step, and applies regardless of en.
REQ-020 en=0 SHALL hold prescaler, step counter, pattern and dir; step SHALL be 0; resuming continues from held counts.

Reset
REQ-021 rst_n=0 SHALL immediately (no clk edge) force led=0, step=0, prescaler=0, step counter=0, dir=up, mode_q=BLINK.
REQ-022 After rst_n release, a mode input other than BLINK SHALL trigger the REQ-019 reload on the first edge.

Configuration
REQ-023 Macro LED_PWM_EN SHALL, when defined, add port duty and a 4-bit free-running PWM counter (advances only while en=1, cleared by reset), with led = pattern AND (pwm_cnt < duty) on every bit; duty=0 gives dark, duty=15 gives 15/16 on-time.
REQ-024 Without LED_PWM_EN, duty port and PWM logic SHALL be absent and led SHALL equal the pattern.

Structure
REQ-025 Shared package SHALL hold the mode encodings (MODE_BLINK/CHASE/BOUNCE/COUNT) and the PWM counter width constant.
REQ-026 Prescaler SHALL be a sub-module tick_gen (parameter TICK_DIV; ports clk, rst_n, en, clr, tick); pattern logic stays in led_pattern_gen.

Verification (CH=8, TICK_DIV=4)
REQ-027 CHASE, speed=0, en=1 after reset -> led 0x01, then 0x02 four cycles later, ..., 0x80, then 0x01; step pulses every 4 cycles.
REQ-028 BOUNCE, speed=0 -> led sequence 0x01,0x02,...,0x80,0x40,...,0x01,0x02; period 14 steps (56 cycles).
REQ-029 BLINK, speed=2 -> led toggles 0x00/0xFF every 16 cycles; en=0 for 10 cycles mid-period delays next toggle by exactly 10 cycles.
REQ-030 COUNT, speed=0 -> led 0xFF after 255 steps, 0x00 at step 256; switch to CHASE mid-count -> led 0x01 next edge, no step pulse, next step 4 cycles later.
REQ-031 Assert rst_n low between clk edges during CHASE -> led=0x00 and step=0 before next edge.
REQ-032 With LED_PWM_EN, BLINK at all-1 phase, duty=4 -> led=0xFF for 4 of every 16 cycles; duty=0 -> led stays 0x00.
